// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: MIPS function codes,
// FSM state encoding and the default datapath width.
package mult_div_unit_pkg;

  localparam int NB_DATA_DEF = 32;

  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MTLO  = 6'b010011;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_muldiv(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_core.sv
// Iterative datapath: shift-add multiply / restoring divide over one shared
// double-width accumulator, iteration down-counter and final sign fix-up.
module mult_div_unit_core
  import mult_div_unit_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = 6,
  parameter int NB_CNT  = $clog2(NB_DATA) + 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_step,
  input  logic [NB_OP-1:0]   i_op,
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  output logic               o_last,
  output logic [NB_DATA-1:0] o_res_hi,
  output logic [NB_DATA-1:0] o_res_lo
);

  logic [2*NB_DATA-1:0] acc_q, acc_d;
  logic [NB_DATA-1:0]   b_q, b_d;
  logic [NB_CNT-1:0]    cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 sign_a_q, sign_a_d;
  logic                 sign_b_q, sign_b_d;
  logic                 div_zero_q, div_zero_d;

  logic                 ld_div, ld_signed;
  logic [NB_DATA-1:0]   mag_a, mag_b;
  logic [NB_DATA:0]     mul_sum, div_trial, div_diff;
  logic                 div_ge;
  logic [2*NB_DATA-1:0] prod_fix;
  logic [NB_DATA-1:0]   quo_fix, rem_fix;

  always_comb begin
    ld_div    = (i_op == OP_DIV) || (i_op == OP_DIVU);
    ld_signed = (i_op == OP_DIV) || (i_op == OP_MULT);
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    is_div_d  = is_div_q;
    div_zero_d = div_zero_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;

    mag_a = (ld_signed && i_data_a[NB_DATA-1]) ? -i_data_a : i_data_a;
    mag_b = (ld_signed && i_data_b[NB_DATA-1]) ? -i_data_b : i_data_b;

    mul_sum   = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} + (acc_q[0] ? {1'b0, b_q} : '0);
    // Remainder shifted left with the next dividend bit needs one extra bit.
    div_trial = acc_q[2*NB_DATA-1:NB_DATA-1];
    div_diff  = div_trial - {1'b0, b_q};
    div_ge    = (div_trial >= {1'b0, b_q});

    if (i_start) begin
      is_div_d   = ld_div;
      sign_a_d   = ld_signed && i_data_a[NB_DATA-1];
      sign_b_d   = ld_signed && i_data_b[NB_DATA-1];
      div_zero_d = ld_div && (i_data_b == '0);
      b_d        = ld_div ? mag_b : mag_a;
      acc_d      = {{NB_DATA{1'b0}}, (ld_div ? mag_a : mag_b)};
      cnt_d      = NB_CNT'(NB_DATA);
    end else if (i_step) begin
      cnt_d = cnt_q - 1'b1;
      if (is_div_q)
        acc_d = {(div_ge ? div_diff[NB_DATA-1:0] : div_trial[NB_DATA-1:0]),
                 acc_q[NB_DATA-2:0], div_ge};
      else
        acc_d = {mul_sum, acc_q[NB_DATA-1:1]};
    end
  end

  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[NB_DATA-1:0] : acc_q[NB_DATA-1:0];
    rem_fix  = sign_a_q ? -acc_q[2*NB_DATA-1:NB_DATA] : acc_q[2*NB_DATA-1:NB_DATA];
    // Zero divisor: restoring divide leaves |a| as remainder, which the
    // dividend-sign fix turns back into raw a; only the quotient is forced.
    if (div_zero_q)
      quo_fix = '1;
    o_res_hi = is_div_q ? rem_fix : prod_fix[2*NB_DATA-1:NB_DATA];
    o_res_lo = is_div_q ? quo_fix : prod_fix[NB_DATA-1:0];
    o_last   = (cnt_q == NB_CNT'(1));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc_q      <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      div_zero_q <= div_zero_d;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// MIPS multiply/divide unit: request handshake, sequencing FSM and the
// architectural HI/LO registers around the iterative core.
//
//   state | meaning
//   IDLE  | accept MTHI/MTLO or start a mult/div
//   CALC  | one multiply/divide iteration per cycle
//   FIX   | sign-corrected result written to HI/LO
//   DONE  | one-cycle completion pulse, requests not accepted
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = 6,
  parameter int NB_CNT  = $clog2(NB_DATA) + 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_OP-1:0]   i_op,
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo
);

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] hi_q, hi_d;
  logic [NB_DATA-1:0] lo_q, lo_d;
  logic               start, step, last;
  logic [NB_DATA-1:0] res_hi, res_lo;

  mult_div_unit_core #(
    .NB_DATA (NB_DATA),
    .NB_OP   (NB_OP),
    .NB_CNT  (NB_CNT)
  ) u_core (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_start  (start),
    .i_step   (step),
    .i_op     (i_op),
    .i_data_a (i_data_a),
    .i_data_b (i_data_b),
    .o_last   (last),
    .o_res_hi (res_hi),
    .o_res_lo (res_lo)
  );

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    start   = 1'b0;
    step    = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          if (i_op == OP_MTHI) begin
            hi_d = i_data_a;
          end else if (i_op == OP_MTLO) begin
            lo_d = i_data_a;
          end else if (is_muldiv(i_op)) begin
            start   = 1'b1;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        o_busy = 1'b1;
        step   = 1'b1;
        if (last)
          state_d = ST_FIX;
      end
      ST_FIX: begin
        o_busy  = 1'b1;
        hi_d    = res_hi;
        lo_d    = res_lo;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign o_hi = hi_q;
  assign o_lo = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: reset, MTHI/MTLO,
// signed/unsigned multiply and divide, corner cases and mid-op reset.
module tb_mult_div_unit;

  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MTLO  = 6'b010011;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [5:0]  op;
  logic [31:0] data_a, data_b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_valid  (valid),
    .i_op     (op),
    .i_data_a (data_a),
    .i_data_b (data_b),
    .o_busy   (busy),
    .o_done   (done),
    .o_hi     (hi),
    .o_lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one mult/div, then expect done in cycle 34 counting the accept
  // cycle as 0, with busy high for the 33 cycles before it.
  task automatic run_op(input string tag, input logic [5:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int c;
    int busy_cnt;
    valid = 1'b1; op = o; data_a = a; data_b = b;
    tick();
    valid = 1'b0;
    c = 1;
    busy_cnt = 0;
    while (!done && c < 60) begin
      if (busy) busy_cnt++;
      tick();
      c++;
    end
    chk({tag, "_done_cycle"}, 64'(c), 64'd34);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    tick();
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int c;
    logic saw_done;
    reset = 1'b1; valid = 1'b0; op = '0; data_a = '0; data_b = '0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    tick();

    valid = 1'b1; op = OP_MTHI; data_a = 32'hA5A5A5A5;
    tick();
    chk("mthi_hi", 64'(hi), 64'hA5A5A5A5);
    chk("mthi_lo", 64'(lo), 64'd0);
    chk("mthi_busy", 64'(busy), 64'd0);
    op = OP_MTLO; data_a = 32'h5A5A5A5A;
    tick();
    chk("mtlo_lo", 64'(lo), 64'h5A5A5A5A);
    chk("mtlo_hi", 64'(hi), 64'hA5A5A5A5);
    chk("mtlo_busy", 64'(busy), 64'd0);
    chk("mtlo_done", 64'(done), 64'd0);
    valid = 1'b0;
    tick();

    // MULT with valid held high; MTLO presented mid-operation is ignored.
    valid = 1'b1; op = OP_MULT; data_a = 32'd2; data_b = 32'd3;
    tick();
    c = 1;
    saw_done = 1'b0;
    while (!done && c < 60) begin
      if (c == 10) begin op = OP_MTLO; data_a = 32'hDEADBEEF; end
      if (c == 20) begin
        chk("hold_lo_mid", 64'(lo), 64'h5A5A5A5A);
        chk("hold_hi_mid", 64'(hi), 64'hA5A5A5A5);
        chk("hold_busy_mid", 64'(busy), 64'd1);
      end
      tick();
      c++;
    end
    valid = 1'b0;
    chk("hold_done_cycle", 64'(c), 64'd34);
    chk("hold_hi", 64'(hi), 64'd0);
    chk("hold_lo", 64'(lo), 64'd6);
    tick();
    tick();
    chk("hold_no_restart", 64'(busy), 64'd0);
    chk("hold_lo_after", 64'(lo), 64'd6);

    run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_mixed", OP_MULT, 32'h00010000, 32'hFFFF0000, 32'hFFFFFFFF, 32'h00000000);
    run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_small", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    run_op("divu_zero", OP_DIVU, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF);
    run_op("div_zero_neg", OP_DIV, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF);
    run_op("divu_big", OP_DIVU, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF);

    // Reset during CALC discards the divide.
    valid = 1'b1; op = OP_DIV; data_a = 32'd100; data_b = 32'd7;
    tick();
    valid = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    chk("abort_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (done || busy) saw_done = 1'b1;
      tick();
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);

    run_op("after_abort", OP_MULTU, 32'h00000010, 32'h00000010, 32'd0, 32'h00000100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
